forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 The module SHALL have parameter NBits, default 32, meaning datapath width (used only by the stall counter).
REQ-002 The module SHALL have parameter RegAddrBits, default 5, meaning register-number width.
REQ-003 The module SHALL use one clock, `clk`, and a synchronous, active-high reset, `reset`.
REQ-004 The module SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port `reset`, input, 1 bit: synchronous, active-high.
REQ-006 The module SHALL have port `ID_Rs`, input, RegAddrBits: rs of the instruction in ID.
REQ-007 The module SHALL have port `ID_Rt`, input, RegAddrBits: rt of the instruction in ID.
REQ-008 The module SHALL have port `ID_WriteReg`, input, RegAddrBits: destination of the instruction in ID.
REQ-009 The module SHALL have port `ID_RegWrite`, input, 1 bit: the ID instruction writes a register.
REQ-010 The module SHALL have port `ID_MemRead`, input, 1 bit: the ID instruction is a load.
REQ-011 The module SHALL have port `Flush`, input, 1 bit: the ID instruction is squashed (taken branch/jump).
REQ-012 The module SHALL have port `ForwardA`, output, 2 bits: operand-A select for the EX stage 3:1 mux.
REQ-013 The module SHALL have port `ForwardB`, output, 2 bits: operand-B select for the EX stage 3:1 mux.
REQ-014 The module SHALL have port `Stall`, output, 1 bit: hold PC and IF/ID; a bubble enters EX.
REQ-015 The module SHALL have port `StallCount`, output, NBits: number of stall cycles (STALL_COUNTER_EN only).

Function
REQ-016 Select encoding SHALL be: 0 = ID/EX register value; 1 = MEM/WB write-back data; 2 = EX/MEM ALU result; 3 never driven.
REQ-017 The unit SHALL keep three internal slots, EX, MEM and WB, each holding {WriteReg, RegWrite, MemRead}, and shift EX->MEM->WB every cycle.
REQ-018 On each edge, the EX slot SHALL load the ID fields, except that it SHALL load a bubble (all zero) when Stall=1 or Flush=1.
REQ-019 ForwardA/ForwardB SHALL be registered outputs, computed from ID_Rs/ID_Rt at the same edge the ID instruction enters EX (latency 1 cycle, aligned with the ID/EX register).
REQ-020 Select 2 SHALL be chosen when the current EX slot has RegWrite=1, WriteReg!=0 and WriteReg equal to the source register.
REQ-021 Otherwise select 1 SHALL be chosen when the current MEM slot has RegWrite=1, WriteReg!=0 and WriteReg equal to the source register; otherwise select 0.
REQ-022 EX/MEM SHALL have priority when both slots match the same source register.
REQ-023 Register 0 SHALL never be forwarded.
REQ-024 ForwardA/ForwardB SHALL be loaded with 0 when a bubble is inserted (Stall or Flush).
REQ-025 The FSM SHALL have states RUN and LOAD_STALL.
REQ-026 In RUN, Stall SHALL be asserted combinationally when the EX slot has MemRead=1, WriteReg!=0 and WriteReg equals ID_Rs or ID_Rt; the FSM SHALL then go to LOAD_STALL.
REQ-027 In LOAD_STALL, Stall SHALL be 0 and the FSM SHALL return to RUN unconditionally; at most one stall cycle SHALL occur per load.
REQ-028 When Flush=1 and a stall condition coincide, Flush SHALL win: Stall=0, a bubble is inserted, and the state stays RUN.
REQ-029 Back-to-back loads with dependent consumers SHALL each produce exactly one stall.

Reset
REQ-030 Reset SHALL clear all slots to bubble and set ForwardA=0, ForwardB=0, Stall=0, state=RUN, and StallCount=0.
REQ-031 Reset asserted mid-stall SHALL take priority, with no residual stall on the next cycle.
REQ-032 Stall SHALL be 0 during reset regardless of inputs.

Configuration
REQ-033 With STALL_COUNTER_EN defined, StallCount SHALL increment by 1 on every cycle with Stall=1 and wrap from 2^NBits-1 to 0.
REQ-034 Without STALL_COUNTER_EN, StallCount SHALL be tied to 0 and the counter SHALL not be built.

Structure
REQ-035 A shared package SHALL hold the select constants (FWD_REG=0, FWD_WB=1, FWD_MEM=2), the FSM state typedef, and the slot struct typedef.
REQ-036 One sub-module, fwd_compare, SHALL compute a single 2-bit select from one source register and the EX/MEM slots; it SHALL be instantiated twice (A and B).

Verification
REQ-037 The bench SHALL cover: add $3 then sub using $3 as rs, back-to-back -> ForwardA=2 in the sub's EX cycle, ForwardB=0.
REQ-038 The bench SHALL cover: add $3, nop, then use of $3 as rt -> ForwardB=1.
REQ-039 The bench SHALL cover: add $3, add $3, then use of $3 -> ForwardA=2 (priority to EX/MEM).
REQ-040 The bench SHALL cover: lw $4, then add using $4 -> Stall=1 for exactly one cycle, then ForwardA=1; with STALL_COUNTER_EN, StallCount=1.
REQ-041 The bench SHALL cover: an instruction writing $0 followed by a use of $0 -> ForwardA=ForwardB=0, Stall=0.
REQ-042 The bench SHALL cover: a load-use hazard with Flush=1 in the same cycle -> Stall=0, bubble inserted, selects 0; and reset asserted during LOAD_STALL -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/forward_hazard_unit_pkg.sv
// rtl/forward_hazard_unit_pkg.sv - shared select constants, FSM state and pipeline slot types
package forward_hazard_unit_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t ST_RUN        = 1'b0;
    localparam fsm_state_t ST_LOAD_STALL = 1'b1;

    // Slots carry a fixed-width register number; narrower RegAddrBits are zero-extended.
    localparam int SLOT_ADDR_BITS = 8;
    typedef logic [SLOT_ADDR_BITS-1:0] slot_addr_t;

    typedef struct packed {
        slot_addr_t write_reg;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    function automatic logic slot_hits(slot_t s, slot_addr_t r);
        return s.reg_write && (s.write_reg != '0) && (s.write_reg == r);
    endfunction

endpackage

// File: rtl/forward_hazard_unit_fwd_compare.sv
// rtl/forward_hazard_unit_fwd_compare.sv - one operand's forwarding select from the EX and MEM slots
module fwd_compare
    import forward_hazard_unit_pkg::*;
(
    input  slot_addr_t src_i,
    input  slot_t      ex_slot_i,
    input  slot_t      mem_slot_i,
    output logic [1:0] sel_o
);

    // The load flag plays no part in forwarding selection.
    logic unused_mem_read;
    assign unused_mem_read = ex_slot_i.mem_read ^ mem_slot_i.mem_read;

    always_comb begin
        sel_o = FWD_REG;
        if (slot_hits(ex_slot_i, src_i)) begin
            sel_o = FWD_MEM;
        end else if (slot_hits(mem_slot_i, src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - forwarding selects and load-use stall; optional counter via STALL_COUNTER_EN
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int NBits       = 32,
    parameter int RegAddrBits = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RegAddrBits-1:0] ID_Rs,
    input  logic [RegAddrBits-1:0] ID_Rt,
    input  logic [RegAddrBits-1:0] ID_WriteReg,
    input  logic                   ID_RegWrite,
    input  logic                   ID_MemRead,
    input  logic                   Flush,
    output logic [1:0]             ForwardA,
    output logic [1:0]             ForwardB,
    output logic                   Stall,
    output logic [NBits-1:0]       StallCount
);

    slot_t      ex_q, mem_q, wb_q;
    slot_t      id_slot;
    fsm_state_t state_q, state_d;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic [1:0] sel_a, sel_b;
    slot_addr_t rs_ext, rt_ext;
    logic       load_use;
    logic       bubble;

    assign rs_ext            = slot_addr_t'(ID_Rs);
    assign rt_ext            = slot_addr_t'(ID_Rt);
    assign id_slot.write_reg = slot_addr_t'(ID_WriteReg);
    assign id_slot.reg_write = ID_RegWrite;
    assign id_slot.mem_read  = ID_MemRead;

    // The WB slot completes the pipeline picture but no select depends on it.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    fwd_compare u_cmp_a (
        .src_i      (rs_ext),
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .sel_o      (sel_a)
    );

    fwd_compare u_cmp_b (
        .src_i      (rt_ext),
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .sel_o      (sel_b)
    );

    assign load_use = ex_q.mem_read && (ex_q.write_reg != '0) &&
                      ((ex_q.write_reg == rs_ext) || (ex_q.write_reg == rt_ext));

    // Flush outranks the stall: the squashed consumer never needs the load result.
    always_comb begin
        Stall   = 1'b0;
        state_d = ST_RUN;
        if (!reset && !Flush && (state_q == ST_RUN) && load_use) begin
            Stall   = 1'b1;
            state_d = ST_LOAD_STALL;
        end
    end

    assign bubble = Stall || Flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
            state_q <= ST_RUN;
        end else begin
            ex_q    <= bubble ? slot_t'('0) : id_slot;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= bubble ? FWD_REG : sel_a;
            fwd_b_q <= bubble ? FWD_REG : sel_b;
            state_q <= state_d;
        end
    end

    assign ForwardA = fwd_a_q;
    assign ForwardB = fwd_b_q;

`ifdef STALL_COUNTER_EN
    logic [NBits-1:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (Stall) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign StallCount = stall_count_q;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - scoreboard bench for forward_hazard_unit
module tb_forward_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_Rs, ID_Rt, ID_WriteReg;
    logic        ID_RegWrite, ID_MemRead, Flush;
    logic [1:0]  ForwardA, ForwardB;
    logic        Stall;
    logic [31:0] StallCount;

    forward_hazard_unit #(.NBits(32), .RegAddrBits(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_WriteReg (ID_WriteReg),
        .ID_RegWrite (ID_RegWrite),
        .ID_MemRead  (ID_MemRead),
        .Flush       (Flush),
        .ForwardA    (ForwardA),
        .ForwardB    (ForwardB),
        .Stall       (Stall),
        .StallCount  (StallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        int wr;
        bit rw;
        bit mr;
    } ins_t;

    exp_t sb[$];
    ins_t hist[$];
    int   m_fa, m_fb;
    int   m_cnt;
    bit   m_prev_stall;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic ins_t bubble_ins();
        ins_t b;
        b.wr = 0; b.rw = 1'b0; b.mr = 1'b0;
        return b;
    endfunction

    // hist[0] is the instruction now in EX, hist[1] the one in MEM.
    function automatic int fwd_of(int r);
        if (r == 0) return 0;
        if (hist[0].rw && hist[0].wr == r) return 2;
        if (hist[1].rw && hist[1].wr == r) return 1;
        return 0;
    endfunction

    function automatic void model_reset();
        hist.delete();
        hist.push_back(bubble_ins());
        hist.push_back(bubble_ins());
        m_fa = 0; m_fb = 0; m_cnt = 0; m_prev_stall = 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int rs, input int rt, input int wr, input bit rw, input bit mr,
                         input bit fl, input bit rst, output bit st);
        exp_t e;
        ins_t n;
        bit   bub;
        int   na, nb;
        @(posedge clk);
        #1;
        ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_WriteReg = 5'(wr);
        ID_RegWrite = rw; ID_MemRead = mr; Flush = fl; reset = rst;

        st = !rst && !fl && !m_prev_stall && hist[0].mr && hist[0].wr != 0 &&
             (hist[0].wr == rs || hist[0].wr == rt);
        e.fa = 2'(m_fa);
        e.fb = 2'(m_fb);
        e.st = st;
`ifdef STALL_COUNTER_EN
        e.cnt = 32'(m_cnt);
`else
        e.cnt = 32'd0;
`endif
        sb.push_back(e);

        if (rst) begin
            model_reset();
        end else begin
            bub = st || fl;
            na  = bub ? 0 : fwd_of(rs);
            nb  = bub ? 0 : fwd_of(rt);
            n.wr = wr; n.rw = rw; n.mr = mr;
            hist.push_front(bub ? bubble_ins() : n);
            void'(hist.pop_back());
            m_fa = na; m_fb = nb;
            m_cnt = m_cnt + (st ? 1 : 0);
            m_prev_stall = st;
        end
    endtask

    // Issues one instruction, re-presenting it while the unit holds IF/ID.
    task automatic ins(input int rs, input int rt, input int wr, input bit rw, input bit mr);
        bit st;
        issue(rs, rt, wr, rw, mr, 1'b0, 1'b0, st);
        if (st) issue(rs, rt, wr, rw, mr, 1'b0, 1'b0, st);
    endtask

    task automatic nop();
        ins(0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ForwardA",   32'(ForwardA), 32'(e.fa));
                chk("ForwardB",   32'(ForwardB), 32'(e.fb));
                chk("Stall",      32'(Stall),    32'(e.st));
                chk("StallCount", StallCount,    e.cnt);
            end
        end
    end

    initial begin : driver
        bit st;
        int rs, rt, wr, kind;
        bit rw, mr, fl, rst;
        bit hold;

        reset = 1'b1;
        ID_Rs = '0; ID_Rt = '0; ID_WriteReg = '0;
        ID_RegWrite = 1'b0; ID_MemRead = 1'b0; Flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        nop();
        // add $3; sub using $3 as rs
        ins(1, 2, 3, 1'b1, 1'b0);
        ins(3, 1, 5, 1'b1, 1'b0);
        nop(); nop();
        // add $3; nop; use $3 as rt
        ins(1, 2, 3, 1'b1, 1'b0);
        nop();
        ins(1, 3, 6, 1'b1, 1'b0);
        nop(); nop();
        // add $3; add $3; use $3
        ins(1, 2, 3, 1'b1, 1'b0);
        ins(2, 1, 3, 1'b1, 1'b0);
        ins(3, 0, 7, 1'b1, 1'b0);
        nop(); nop();
        // lw $4; add using $4
        ins(0, 0, 4, 1'b1, 1'b1);
        ins(4, 2, 8, 1'b1, 1'b0);
        nop(); nop();
        // back-to-back loads with dependent consumers
        ins(0, 0, 4, 1'b1, 1'b1);
        ins(4, 0, 5, 1'b1, 1'b1);
        ins(5, 4, 9, 1'b1, 1'b0);
        nop(); nop();
        // write $0 then use $0
        ins(1, 2, 0, 1'b1, 1'b0);
        ins(0, 0, 10, 1'b1, 1'b0);
        ins(0, 0, 0, 1'b1, 1'b1);
        ins(0, 0, 11, 1'b1, 1'b0);
        nop(); nop();
        // load-use with coincident flush
        ins(0, 0, 4, 1'b1, 1'b1);
        issue(4, 4, 12, 1'b1, 1'b0, 1'b1, 1'b0, st);
        nop(); nop();
        // reset asserted during the LOAD_STALL cycle
        ins(0, 0, 4, 1'b1, 1'b1);
        issue(4, 1, 13, 1'b1, 1'b0, 1'b0, 1'b0, st);
        issue(4, 1, 13, 1'b1, 1'b0, 1'b0, 1'b1, st);
        nop(); nop();

        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                rs   = $urandom_range(0, 3);
                rt   = $urandom_range(0, 3);
                wr   = $urandom_range(0, 3);
                kind = $urandom_range(0, 3);
                rw   = (kind != 0);
                mr   = (kind == 2);
            end
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 59) == 0);
            issue(rs, rt, wr, rw, mr, fl, rst, st);
            hold = st;
        end

        nop(); nop();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
